// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// fetch_unit_if : fetch-stage bus (PC to instmem, redirect in, decode handshake)
// Rev 1.0
// ============================================================================
interface fetch_unit_if;
   logic [31:0] pc;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic [31:0] mem_inst;
   logic        id_ready;
   logic        if_valid;
   logic [31:0] if_inst;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus1;
   logic        if_oob;

   modport master (
      output pc,
      input  redirect_valid,
      input  redirect_target,
      input  mem_inst,
      input  id_ready,
      output if_valid,
      output if_inst,
      output if_pc,
      output if_pc_plus1,
      output if_oob
   );

   modport slave (
      input  pc,
      output redirect_valid,
      output redirect_target,
      output mem_inst,
      output id_ready,
      input  if_valid,
      input  if_inst,
      input  if_pc,
      input  if_pc_plus1,
      input  if_oob
   );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : PC owner, instmem address driver, 2-entry fetch buffer to decode
// Rev 1.0
// ============================================================================
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'd0,
   parameter int unsigned IMEM_WORDS = 128
) (
   input  wire logic    clk,
   input  wire logic    rst_n,
   fetch_unit_if.master fif
);
   localparam logic [31:0] c_imem_words = 32'(IMEM_WORDS);

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        oob;
   } entry_t;

   logic [31:0] pc_q, pc_d;
   logic        tag_vld_q, tag_vld_d;
   logic [31:0] tag_pc_q, tag_pc_d;
   logic [1:0]  count_q, count_d;
   entry_t      ent0_q, ent0_d;
   entry_t      ent1_q, ent1_d;

   logic        w_pop;
   logic        w_push;
   logic        w_issue;
   logic [1:0]  w_count_next;
   logic [1:0]  w_wr_slot;
   entry_t      w_new;

   assign w_pop        = (count_q != 2'd0) & fif.id_ready;
   assign w_push       = tag_vld_q & ~fif.redirect_valid;
   assign w_count_next = count_q + {1'b0, w_push} - {1'b0, w_pop};
   // Only issue when the word returning next cycle is guaranteed a free slot.
   assign w_issue      = ~fif.redirect_valid & (w_count_next <= 2'd1);
   assign w_wr_slot    = count_q - {1'b0, w_pop};

   assign w_new.inst = fif.mem_inst;
   assign w_new.pc   = tag_pc_q;
   assign w_new.oob  = (tag_pc_q >= c_imem_words);

   always_comb begin
      pc_d      = pc_q;
      tag_vld_d = 1'b0;
      tag_pc_d  = tag_pc_q;
      count_d   = w_count_next;
      ent0_d    = ent0_q;
      ent1_d    = ent1_q;
      if (fif.redirect_valid) begin
         count_d = 2'd0;
         pc_d    = fif.redirect_target;
      end else begin
         if (w_pop) begin
            ent0_d = ent1_q;
         end
         if (w_push) begin
            if (w_wr_slot == 2'd0) begin
               ent0_d = w_new;
            end else begin
               ent1_d = w_new;
            end
         end
         if (w_issue) begin
            tag_vld_d = 1'b1;
            tag_pc_d  = pc_q;
            pc_d      = pc_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q      <= RESET_PC;
         tag_vld_q <= 1'b0;
         tag_pc_q  <= 32'd0;
         count_q   <= 2'd0;
         ent0_q    <= '0;
         ent1_q    <= '0;
      end else begin
         pc_q      <= pc_d;
         tag_vld_q <= tag_vld_d;
         tag_pc_q  <= tag_pc_d;
         count_q   <= count_d;
         ent0_q    <= ent0_d;
         ent1_q    <= ent1_d;
      end
   end

   assign fif.pc          = pc_q;
   assign fif.if_valid    = (count_q != 2'd0);
   assign fif.if_inst     = ent0_q.inst;
   assign fif.if_pc       = ent0_q.pc;
   assign fif.if_pc_plus1 = ent0_q.pc + 32'd1;
   assign fif.if_oob      = ent0_q.oob;
endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_fetch_unit : directed vector table plus randomized scoreboard run
// Rev 1.0
// ============================================================================
module tb_fetch_unit;
   localparam logic [31:0] RESET_PC   = 32'd0;
   localparam int unsigned IMEM_WORDS = 128;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   fetch_unit_if fif();

   fetch_unit #(
      .RESET_PC   (RESET_PC),
      .IMEM_WORDS (IMEM_WORDS)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .fif   (fif)
   );

   always #5 clk = ~clk;

   // Memory contents are a bijective scramble of the address, so any word is checkable.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h5A3C};
   endfunction

   always @(posedge clk) fif.mem_inst <= mem_word(fif.pc);

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rdy, input logic redir, input logic [31:0] tgt);
      fif.id_ready        = rdy;
      fif.redirect_valid  = redir;
      fif.redirect_target = tgt;
   endtask

   typedef struct {
      logic        rdy;
      logic        redir;
      logic [31:0] tgt;
      logic        exp_v;
      logic [31:0] exp_ipc;
      logic [31:0] exp_fpc;
   } vec_t;

   vec_t vecs[23];

   task automatic check_head(input string tag, input logic [31:0] exp_ipc);
      check({tag, "_if_pc"}, fif.if_pc, exp_ipc);
      check({tag, "_if_inst"}, fif.if_inst, mem_word(exp_ipc));
      check({tag, "_if_pc_plus1"}, fif.if_pc_plus1, exp_ipc + 32'd1);
      check({tag, "_if_oob"}, {31'd0, fif.if_oob}, {31'd0, (exp_ipc >= 32'(IMEM_WORDS))});
   endtask

   task automatic run_rows(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         drive(vecs[i].rdy, vecs[i].redir, vecs[i].tgt);
         check($sformatf("row%0d_valid", i), {31'd0, fif.if_valid}, {31'd0, vecs[i].exp_v});
         check($sformatf("row%0d_pc", i), fif.pc, vecs[i].exp_fpc);
         if (vecs[i].exp_v) check_head($sformatf("row%0d", i), vecs[i].exp_ipc);
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_valid"}, {31'd0, fif.if_valid}, 32'd0);
      check({tag, "_pc"}, fif.pc, RESET_PC);
      check({tag, "_if_inst"}, fif.if_inst, 32'd0);
      check({tag, "_if_pc"}, fif.if_pc, 32'd0);
      check({tag, "_if_oob"}, {31'd0, fif.if_oob}, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] exp_next, fpc_exp, hold_pc, hold_inst, tgt, ipc, inst;
      logic        v, rdy, redir, hold, fpc_pend;
      int          bubble, idle, accepted;

      // rdy, redir, target, exp if_valid, exp if_pc, exp pc
      vecs[0]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0};
      vecs[1]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h1};
      vecs[2]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0,         32'h2};
      vecs[3]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h1,         32'h3};
      vecs[4]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h2,         32'h4};
      vecs[5]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h3,         32'h5};
      vecs[6]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h3,         32'h5};
      vecs[7]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h3,         32'h5};
      vecs[8]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h3,         32'h5};
      vecs[9]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h3,         32'h5};
      vecs[10] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h3,         32'h5};
      vecs[11] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h4,         32'h6};
      vecs[12] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h5,         32'h7};
      vecs[13] = '{1'b0, 1'b1, 32'h40,        1'b1, 32'h5,         32'h7};
      vecs[14] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h40};
      vecs[15] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h41};
      vecs[16] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h40,        32'h42};
      vecs[17] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h41,        32'h43};
      vecs[18] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'hFFFF_FFFF};
      vecs[19] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0};
      vecs[20] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFF, 32'h1};
      vecs[21] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0,         32'h2};
      vecs[22] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h1,         32'h3};

      drive(1'b0, 1'b0, 32'h0);
      #1 rst_n = 1'b0;
      @(negedge clk);
      check_reset_state("reset");
      @(negedge clk);
      rst_n = 1'b1;
      run_rows(0, 22);

      // Build up two buffered entries, then reset asynchronously mid-stall.
      drive(1'b0, 1'b0, 32'h0);
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
      end
      check("stall_valid", {31'd0, fif.if_valid}, 32'd1);
      check("stall_if_pc", fif.if_pc, 32'h2);
      check("stall_pc", fif.pc, 32'h4);
      rst_n = 1'b0;
      #1;
      check_reset_state("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      run_rows(0, 5);

      // Randomized phase, anchored by a redirect with no pop in flight.
      drive(1'b0, 1'b1, 32'h100);
      exp_next  = 32'h100;
      fpc_exp   = 32'h100;
      fpc_pend  = 1'b1;
      bubble    = 2;
      idle      = 0;
      hold      = 1'b0;
      hold_pc   = 32'h0;
      hold_inst = 32'h0;
      accepted  = 0;
      for (int n = 0; n < 3000; n++) begin
         @(posedge clk);
         @(negedge clk);
         v    = fif.if_valid;
         ipc  = fif.if_pc;
         inst = fif.if_inst;
         if (fpc_pend) begin
            check("rnd_redirect_pc", fif.pc, fpc_exp);
            fpc_pend = 1'b0;
         end
         if (bubble > 0) begin
            check("rnd_bubble_valid", {31'd0, v}, 32'd0);
            bubble--;
         end
         if (hold) begin
            check("rnd_hold_valid", {31'd0, v}, 32'd1);
            check("rnd_hold_if_pc", ipc, hold_pc);
            check("rnd_hold_if_inst", inst, hold_inst);
         end
         idle = v ? 0 : idle + 1;
         checks++;
         if (idle > 4) begin
            failures++;
            $display("FAIL rnd_liveness actual=idle_%0d required=idle_le_4", idle);
            idle = 0;
         end
         rdy   = ($urandom_range(0, 3) != 0);
         redir = ($urandom_range(0, 19) == 0);
         case ($urandom_range(0, 4))
            0:       tgt = 32'h40;
            1:       tgt = 32'h7C;
            2:       tgt = 32'hFFFF_FFFD;
            3:       tgt = 32'h200;
            default: tgt = $urandom;
         endcase
         if (v && rdy) begin
            check_head("rnd", exp_next);
            exp_next = exp_next + 32'd1;
            accepted++;
         end
         if (redir) begin
            exp_next = tgt;
            fpc_exp  = tgt;
            fpc_pend = 1'b1;
            bubble   = 2;
            idle     = 0;
         end
         hold      = v & ~rdy & ~redir;
         hold_pc   = ipc;
         hold_inst = inst;
         drive(rdy, redir, redir ? tgt : 32'h0);
      end
      checks++;
      if (accepted < 1000) begin
         failures++;
         $display("FAIL rnd_throughput actual=%0d required=ge_1000", accepted);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage directly upstream of the instruction memory. Owns the program counter, drives the word address into `instmem`, pairs the memory's one-cycle-late registered instruction with the address that produced it, and hands instruction/PC pairs to decode through a 2-entry buffer with valid/ready flow control. Branch/jump redirects from later stages squash all wrong-path fetches.

## Interface
- `RESET_PC`, 0: word address fetched first after reset.
- `IMEM_WORDS`, 128: instruction memory depth in words; used only for out-of-range tagging.
- `clk`  in  1  rising-edge clock, shared with `instmem`.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `redirect_valid`  in  1  taken branch/jump this cycle.
- `redirect_target`  in  32  word address to fetch next when `redirect_valid`.
- `mem_inst`  in  32  instruction from `instmem`; equals mem[`pc` of previous cycle].
- `id_ready`  in  1  decode accepts head entry this cycle.
- `pc`  out  32  word address to `instmem` (registered, `pc_q`).
- `if_valid`  out  1  head entry valid.
- `if_inst`  out  32  head instruction.
- `if_pc`  out  32  word address of head instruction.
- `if_pc_plus1`  out  32  `if_pc + 1` (mod 2^32), base for branch-target arithmetic.
- `if_oob`  out  1  `if_pc >= IMEM_WORDS`; qualified by `if_valid`.

## Operation
- `pc` is a word index, not a byte address; sequential fetch increments by 1.
- State: `pc_q`, in-flight tag (`tag_vld`, `tag_pc`), 2-entry FIFO (`count` 0..2, each entry holds inst, pc, oob).
- Per cycle: `pop = if_valid & id_ready`; `push = tag_vld & ~redirect_valid` (data `mem_inst`, pc `tag_pc`); `count_next = count + push - pop`.
- Issue rule: `issue = ~redirect_valid & (count_next <= 1)`. On issue: `tag_pc <= pc_q`, `tag_vld <= 1`, `pc_q <= pc_q + 1`. Otherwise `tag_vld <= 0`, `pc_q` holds (memory re-reads same word harmlessly).
- Credit rule guarantees a push never finds the FIFO full; FIFO overflow is impossible by construction, no replay path exists.
- Redirect: FIFO cleared (`count <= 0`), `tag_vld <= 0`, `pc_q <= redirect_target`. Redirect beats simultaneous pop and push; the pop's handshake still completes for decode.
- Head outputs show FIFO entry 0; `if_inst`/`if_pc` are don't-care when `if_valid=0` but must not change while `if_valid & ~id_ready`.
- PC increment wraps 0xFFFF_FFFF -> 0x0000_0000; `if_pc_plus1` wraps likewise.
- `if_oob` computed at push from `tag_pc` and stored with the entry.

## Timing
- Reset (async, immediate): `pc_q=RESET_PC`, `tag_vld=0`, `count=0`, `if_valid=0`, `if_inst=0`, `if_pc=0`, `if_oob=0`.
- First edge after `rst_n` rises (E0): issue of `RESET_PC`. After E1: `if_valid=1`, `if_pc=RESET_PC`. Fetch-to-decode latency 2 cycles.
- Steady `id_ready=1`: one instruction per cycle, consecutive `if_pc` values.
- `id_ready=0` stall: at most 2 entries buffered; `pc` freezes; on release the next sequential instruction follows the buffered ones with no gap beyond one bubble.
- Redirect asserted in cycle N: `pc=redirect_target` after edge N; first target instruction `if_valid` after edge N+2 (2-cycle bubble); nothing fetched before edge N is ever presented afterward.
- Reset asserted mid-operation: all state returns to reset values asynchronously; buffered entries discarded.

## Test plan
- Reset boot, `RESET_PC=0`, memory words 0..3 distinct, `id_ready=1` -> `if_valid` rises 2 edges after reset release; `if_pc` sequence 0,1,2,3 with matching `if_inst`, `if_pc_plus1` 1,2,3,4.
- Backpressure: drop `id_ready` for 5 cycles mid-stream -> `count` peaks at 2, `pc` frozen, head stable; after release order continuous, no skip or duplicate.
- Redirect to 0x40 while 2 entries buffered -> `if_valid=0` for 2 cycles, next `if_pc=0x40`, no stale entry emitted.
- Redirect coincident with pop and push -> redirect wins; only target-path instructions follow; popped entry counted once.
- `redirect_target=0xFFFF_FFFF`, `IMEM_WORDS=128` -> `if_pc` 0xFFFF_FFFF with `if_oob=1`, then 0x0 with `if_oob=0`, `if_pc_plus1` 0x0 then 0x1.
- Assert `rst_n` low mid-stall with 2 entries -> outputs zero and `pc=RESET_PC` immediately (before next edge); restart repeats boot sequence.
